// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared definitions for the two-way tag lookup controller: FSM encoding,
// tag-entry layout and default widths.
package tag_lookup_ctrl_pkg;

    localparam int DEF_AWIDTH = 3;
    localparam int DEF_TWIDTH = 15;

    // Entry layout is {valid, tag}; the valid flag sits just above the tag.
    localparam int VALID_BIT = DEF_TWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_REFILL  = 2'd2,
        ST_WRITE   = 2'd3
    } state_e;

    function automatic int valid_bit_pos(input int twidth);
        return twidth;
    endfunction

endpackage

// File: rtl/tag_lookup_ctrl_lru_array_2way.sv
// Per-set LRU bit for a two-way cache: holds the way to evict next.
// Combinational read, single synchronous update port, cleared by reset.
module lru_array_2way #(
    parameter int AWIDTH = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [AWIDTH-1:0] i_rd_idx,
    output logic              o_rd_lru,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_idx,
    input  logic              i_wr_lru
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DEPTH-1:0] r_bits;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bits <= '0;
        end else if (i_wr_en) begin
            r_bits[i_wr_idx] <= i_wr_lru;
        end
    end

    assign o_rd_lru = r_bits[i_rd_idx];

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Two-way set-associative tag lookup controller: compares both ways, refills
// on a miss through the next level, and writes the victim tag entry.
module tag_lookup_ctrl
    import tag_lookup_ctrl_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int TWIDTH = DEF_TWIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [TWIDTH+AWIDTH-1:0] req_addr,
    output logic                     rsp_valid,
    output logic                     rsp_hit,
    output logic                     rsp_way,
    output logic                     refill_req,
    output logic [TWIDTH+AWIDTH-1:0] refill_addr,
    input  logic                     refill_done,
    output logic [AWIDTH-1:0]        t0_addr,
    output logic [AWIDTH-1:0]        t1_addr,
    output logic [TWIDTH:0]          t0_din,
    output logic [TWIDTH:0]          t1_din,
    output logic                     t0_we,
    output logic                     t1_we,
    input  logic [TWIDTH:0]          t0_dout,
    input  logic [TWIDTH:0]          t1_dout
);

    localparam int VB = valid_bit_pos(TWIDTH);

    state_e                     r_state;
    logic [TWIDTH+AWIDTH-1:0]   r_addr;
    logic                       r_victim;

    logic [AWIDTH-1:0]          w_idx;
    logic [TWIDTH-1:0]          w_tag;
    logic                       w_hit0;
    logic                       w_hit1;
    logic                       w_hit_way;
    logic                       w_lru_rd;
    logic                       w_miss_victim;
    logic                       w_cmp_hit;
    logic                       w_write;
    logic                       w_lru_we;
    logic                       w_lru_wr;

    assign w_idx = r_addr[AWIDTH-1:0];
    assign w_tag = r_addr[TWIDTH+AWIDTH-1:AWIDTH];

    assign w_hit0    = t0_dout[VB] && (t0_dout[TWIDTH-1:0] == w_tag);
    assign w_hit1    = t1_dout[VB] && (t1_dout[TWIDTH-1:0] == w_tag);
    assign w_hit_way = !w_hit0;

    // Prefer an empty way before evicting by LRU.
    assign w_miss_victim = !t0_dout[VB] ? 1'b0 :
                           !t1_dout[VB] ? 1'b1 : w_lru_rd;

    // Reset masks every side effect so an abandoned request writes nothing.
    assign w_cmp_hit = (r_state == ST_COMPARE) && (w_hit0 || w_hit1) && !reset;
    assign w_write   = (r_state == ST_WRITE) && !reset;

    assign w_lru_we = w_cmp_hit || w_write;
    assign w_lru_wr = w_cmp_hit ? !w_hit_way : !r_victim;

    lru_array_2way #(
        .AWIDTH (AWIDTH)
    ) u_lru (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_rd_idx (w_idx),
        .o_rd_lru (w_lru_rd),
        .i_wr_en  (w_lru_we),
        .i_wr_idx (w_idx),
        .i_wr_lru (w_lru_wr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_victim <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (w_hit0 || w_hit1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_victim <= w_miss_victim;
                        r_state  <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (refill_done) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Hit results depend on RAM data arriving in COMPARE, so responses are
    // decoded from state rather than registered to keep accept+1 latency.
    assign req_ready   = (r_state == ST_IDLE);
    assign refill_req  = (r_state == ST_REFILL) && !reset;
    assign refill_addr = r_addr;

    assign t0_addr = (r_state == ST_IDLE) ? req_addr[AWIDTH-1:0] : w_idx;
    assign t1_addr = (r_state == ST_IDLE) ? req_addr[AWIDTH-1:0] : w_idx;
    assign t0_din  = {1'b1, w_tag};
    assign t1_din  = {1'b1, w_tag};
    assign t0_we   = w_write && !r_victim;
    assign t1_we   = w_write && r_victim;

    assign rsp_valid = w_cmp_hit || w_write;
    assign rsp_hit   = w_cmp_hit;
    assign rsp_way   = w_cmp_hit ? w_hit_way : (w_write && r_victim);

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: models both tag RAMs, drives directed and random
// lookups, and predicts every response from a transaction-level cache model.
module tb_tag_lookup_ctrl;

    localparam int AW = 3;
    localparam int TW = 15;
    localparam int DEPTH = 1 << AW;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [TW+AW-1:0]  req_addr;
    logic              rsp_valid;
    logic              rsp_hit;
    logic              rsp_way;
    logic              refill_req;
    logic [TW+AW-1:0]  refill_addr;
    logic              refill_done;
    logic [AW-1:0]     t0_addr;
    logic [AW-1:0]     t1_addr;
    logic [TW:0]       t0_din;
    logic [TW:0]       t1_din;
    logic              t0_we;
    logic              t1_we;
    logic [TW:0]       t0_dout;
    logic [TW:0]       t1_dout;

    // Tag RAMs; the pl_* port lets the bench load contents between requests.
    logic [TW:0]       mem0 [0:DEPTH-1] = '{default: '0};
    logic [TW:0]       mem1 [0:DEPTH-1] = '{default: '0};
    logic              pl_we = 1'b0;
    logic              pl_way = 1'b0;
    logic [AW-1:0]     pl_idx = '0;
    logic [TW:0]       pl_data = '0;

    // Reference model: contents and replacement order per set.
    bit                m_v   [2][DEPTH];
    logic [TW-1:0]     m_t   [2][DEPTH];
    bit                m_lru [DEPTH];

    int n_chk = 0;
    int n_pass = 0;

    tag_lookup_ctrl #(
        .AWIDTH (AW),
        .TWIDTH (TW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_way     (rsp_way),
        .refill_req  (refill_req),
        .refill_addr (refill_addr),
        .refill_done (refill_done),
        .t0_addr     (t0_addr),
        .t1_addr     (t1_addr),
        .t0_din      (t0_din),
        .t1_din      (t1_din),
        .t0_we       (t0_we),
        .t1_we       (t1_we),
        .t0_dout     (t0_dout),
        .t1_dout     (t1_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pl_we) begin
            if (pl_way) mem1[pl_idx] <= pl_data;
            else        mem0[pl_idx] <= pl_data;
        end else begin
            if (t0_we) mem0[t0_addr] <= t0_din;
            if (t1_we) mem1[t1_addr] <= t1_din;
        end
        t0_dout <= mem0[t0_addr];
        t1_dout <= mem1[t1_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clock) begin
        #2;
        if (t0_we || t1_we) chk("we_exclusive", {31'd0, t0_we & t1_we}, 32'd0);
    end

    task automatic preload(input bit way, input int idx, input bit v, input logic [TW-1:0] tag);
        @(negedge clock);
        req_valid = 1'b0;
        pl_we = 1'b1; pl_way = way; pl_idx = AW'(idx); pl_data = {v, tag};
        @(negedge clock);
        pl_we = 1'b0;
        m_v[way][idx] = v;
        m_t[way][idx] = tag;
    endtask

    task automatic clear_lru_model();
        for (int i = 0; i < DEPTH; i++) m_lru[i] = 1'b0;
    endtask

    // abort: 0 = complete normally, 1 = reset while in refill, 2 = reset in write
    task automatic do_req(input logic [TW+AW-1:0] addr, input int dly, input bit hold, input int abort);
        int            idx;
        logic [TW-1:0] tag;
        bit            h0, h1, way, vic;
        idx = int'(addr[AW-1:0]);
        tag = addr[TW+AW-1:AW];
        @(negedge clock);
        req_valid = 1'b1;
        req_addr = addr;
        #1;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        chk("taddr_idle", {29'd0, t0_addr}, idx);
        h0 = m_v[0][idx] && (m_t[0][idx] == tag);
        h1 = m_v[1][idx] && (m_t[1][idx] == tag);

        @(negedge clock);
        if (hold && abort == 0) req_addr = addr ^ {{TW{1'b1}}, {AW{1'b0}}};
        else req_valid = 1'b0;
        #1;
        chk("ready_busy", {31'd0, req_ready}, 32'd0);
        chk("taddr_latched", {29'd0, t1_addr}, idx);
        if (h0 || h1) begin
            way = h0 ? 1'b0 : 1'b1;
            chk("hit_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hit_flag", {31'd0, rsp_hit}, 32'd1);
            chk("hit_way", {31'd0, rsp_way}, {31'd0, way});
            chk("hit_no_refill", {31'd0, refill_req}, 32'd0);
            m_lru[idx] = ~way;
            req_valid = 1'b0;
            return;
        end
        chk("miss_no_rsp", {31'd0, rsp_valid}, 32'd0);
        vic = !m_v[0][idx] ? 1'b0 : (!m_v[1][idx] ? 1'b1 : m_lru[idx]);

        @(negedge clock);
        refill_done = (dly == 0) && (abort != 1);
        #1;
        chk("refill_req", {31'd0, refill_req}, 32'd1);
        chk("refill_addr", {14'd0, refill_addr}, {14'd0, addr});
        chk("ready_refill", {31'd0, req_ready}, 32'd0);
        for (int k = 1; k <= dly; k++) begin
            @(negedge clock);
            refill_done = (k == dly) && (abort != 1);
            #1;
            chk("refill_held", {31'd0, refill_req}, 32'd1);
            chk("no_we_refill", {31'd0, t0_we | t1_we}, 32'd0);
        end

        if (abort == 1) begin
            @(negedge clock);
            reset = 1'b1;
            refill_done = 1'b1;
            #1;
            chk("rst_refill_we", {31'd0, t0_we | t1_we}, 32'd0);
            chk("rst_refill_rsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clock);
            reset = 1'b0;
            #1;
            chk("rst_refill_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_refill_req", {31'd0, refill_req}, 32'd0);
            chk("rst_refill_we2", {31'd0, t0_we | t1_we}, 32'd0);
            chk("rst_refill_rsp2", {31'd0, rsp_valid}, 32'd0);
            @(negedge clock);
            refill_done = 1'b0;
            #1;
            chk("rst_refill_idle", {31'd0, req_ready}, 32'd1);
            clear_lru_model();
            return;
        end

        @(negedge clock);
        refill_done = 1'b0;
        if (abort == 2) reset = 1'b1;
        #1;
        if (abort == 2) begin
            chk("rst_write_we0", {31'd0, t0_we}, 32'd0);
            chk("rst_write_we1", {31'd0, t1_we}, 32'd0);
            chk("rst_write_rsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clock);
            reset = 1'b0;
            #1;
            chk("rst_write_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_write_rsp2", {31'd0, rsp_valid}, 32'd0);
            clear_lru_model();
            return;
        end
        chk("write_we0", {31'd0, t0_we}, {31'd0, !vic});
        chk("write_we1", {31'd0, t1_we}, {31'd0, vic});
        chk("write_din", {16'd0, vic ? t1_din : t0_din}, {16'd0, 1'b1, tag});
        chk("write_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("write_rsp_hit", {31'd0, rsp_hit}, 32'd0);
        chk("write_rsp_way", {31'd0, rsp_way}, {31'd0, vic});
        chk("ready_write", {31'd0, req_ready}, 32'd0);
        m_v[vic][idx] = 1'b1;
        m_t[vic][idx] = tag;
        m_lru[idx] = ~vic;
    endtask

    initial begin
        logic [TW-1:0] rtag;
        int            ridx;
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        refill_done = 1'b0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DEPTH; i++) begin
                m_v[w][i] = 1'b0;
                m_t[w][i] = '0;
            end
        clear_lru_model();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_hit", {31'd0, rsp_hit}, 32'd0);
        chk("rst_rsp_way", {31'd0, rsp_way}, 32'd0);
        chk("rst_refill_req", {31'd0, refill_req}, 32'd0);
        chk("rst_we", {30'd0, t1_we, t0_we}, 32'd0);

        // Hit in way 1, then a miss at the same set evicts way 0 per LRU.
        preload(1'b1, 2, 1'b1, 15'h1234);
        do_req({15'h1234, 3'd2}, 0, 1'b0, 0);
        preload(1'b0, 2, 1'b1, 15'h0001);
        do_req({15'h0777, 3'd2}, 1, 1'b0, 0);

        // Cold miss with a four-cycle refill.
        do_req({15'h0042, 3'd5}, 4, 1'b0, 0);

        // Both ways valid, LRU points at way 1; refill it and re-hit.
        preload(1'b0, 1, 1'b1, 15'h0010);
        preload(1'b1, 1, 1'b1, 15'h0011);
        do_req({15'h0010, 3'd1}, 0, 1'b0, 0);
        do_req({15'h0099, 3'd1}, 2, 1'b0, 0);
        do_req({15'h0099, 3'd1}, 0, 1'b0, 0);

        // Request held high through a miss, followed directly by another.
        do_req({15'h0abc, 3'd6}, 3, 1'b1, 0);
        do_req({15'h0abc, 3'd6}, 0, 1'b0, 0);

        // Duplicate valid tag in both ways resolves to way 0.
        preload(1'b0, 3, 1'b1, 15'h0055);
        preload(1'b1, 3, 1'b1, 15'h0055);
        do_req({15'h0055, 3'd3}, 0, 1'b0, 0);

        // refill_done already high on the first refill cycle.
        do_req({15'h0321, 3'd7}, 0, 1'b0, 0);

        // Reset during refill and during write abandons the request.
        do_req({15'h0500, 3'd4}, 2, 1'b0, 1);
        do_req({15'h0500, 3'd4}, 0, 1'b0, 0);
        do_req({15'h0600, 3'd0}, 1, 1'b0, 2);
        do_req({15'h0600, 3'd0}, 1, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                rtag = 15'h0100 + 15'($urandom_range(0, 5));
                preload(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                        1'($urandom_range(0, 1)), rtag);
            end
            rtag = 15'h0100 + 15'($urandom_range(0, 5));
            ridx = int'($urandom_range(0, DEPTH - 1));
            do_req({rtag, AW'(ridx)}, int'($urandom_range(0, 4)),
                   ($urandom_range(0, 3) == 0), 0);
        end

        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
